multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control unit for the multicycle MIPS-subset datapath; consumes opc[5:0], func[5:0] and zero, and produces every datapath select/enable.
- Moore FSM (one instruction per 3–5 cycles) plus a combinational ALU-control decoder.
- Instantiated beside the datapath in the top-level CPU; shares its clk/rst.

Parameters:
- None. All opcode, func, ALU-op and state encodings are package constants.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opc  in  6  IR[31:26] from datapath
- func  in  6  IR[5:0] from datapath
- zero  in  1  ALU zero flag (combinational, current cycle)
- PCLoad  out  1  PC register load
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- JalSig1  out  1  force write register to 31
- MemToReg  out  1  write data select: 0 = ALUOut, 1 = MDR
- JalSig2  out  1  force write data to PC
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 0 = B, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- ALUOperation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- PCSrc  out  2  PC source: 0 = ALU result, 1 = jump target, 2 = ALUOut, 3 = A

Behaviour:
- Reset: asynchronous; state <= FETCH. While rst = 1, PCLoad, MemRead, MemWrite, IRWrite and RegWrite are forced 0. Every other output takes its FETCH value.
- Output rule: all outputs are a pure function of the state, except PCLoad in BEQ/BNE (gated by zero) and ALUOperation in RT_EX (taken from func). Any output not listed for a state is 0.
- FETCH: MemRead, IRWrite, ALUSrcB=1, ALUOp=ADD, PCSrc=0, PCLoad. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, so the branch target is latched into ALUOut. Next state by opc:
  - 000000 with func 001000 -> JR; any other 000000 -> RT_EX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ; 000101 -> BNE
  - 000010 -> JUMP; 000011 -> JAL
  - 001000 -> ADDI_EX; 001010 -> SLTI_EX
  - any other opcode -> FETCH (treated as NOP; PC already advanced)
- MEMADR: ALUSrcA=1, ALUSrcB=2, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead. Next state MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite. Next state FETCH.
- MEMWR: IorD=1, MemWrite. Next state FETCH.
- RT_EX: ALUSrcA=1, ALUSrcB=0, ALUOp from func:
  - 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 101010 -> SLT
  - any other func -> ADD (result still written back)
  - Next state RT_WB.
- RT_WB: RegDst=1, MemToReg=0, RegWrite. Next state FETCH.
- ADDI_EX / SLTI_EX: ALUSrcA=1, ALUSrcB=2, ALUOp ADD / SLT respectively. Next state IMM_WB.
- IMM_WB: RegDst=0, MemToReg=0, RegWrite. Next state FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=2, PCLoad = zero. Next state FETCH.
- BNE: as BEQ, but PCLoad = ~zero.
- JUMP: PCSrc=1, PCLoad. Next state FETCH.
- JAL: JalSig1, JalSig2, RegWrite, PCSrc=1, PCLoad. $31 receives PC+4 because PC was advanced in FETCH. Next state FETCH.
- JR: PCSrc=3, PCLoad. Next state FETCH. A holds rs, latched in DECODE.
- Latency in cycles: lw 5; R-type, sw, addi, slti 4; beq, bne, j, jal, jr 3; unknown opcode 2.
- Illegal state encoding: next state FETCH, with all enables 0 in that cycle.
- Reset asserted mid-instruction: the instruction is aborted immediately; no write enable is asserted after the rst edge.

Decomposition:
- Package cpu_defs holds:
  - opcode and func constants
  - ALUOperation codes
  - ALUSrcB and PCSrc select codes
  - state enum (4-bit encoding)
- One sub-module, alu_control: func[5:0] -> ALUOperation[2:0] (combinational), used only in RT_EX.

Test Plan:
- Reset, then opc=100011: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. MEMWB has RegWrite=1, MemToReg=1, RegDst=0; MEMRD has IorD=1.
- R-type, func=100010: RT_EX has ALUOperation=110, ALUSrcA=1, ALUSrcB=0. RT_WB has RegDst=1, RegWrite=1. Instruction takes 4 cycles.
- opc=000100: with zero=1, BEQ has PCLoad=1 and PCSrc=2. With zero=0, PCLoad=0. Repeat with opc=000101 and check the inverted condition.
- opc=000011: JAL has JalSig1=1, JalSig2=1, RegWrite=1, PCSrc=1, PCLoad=1. Then FETCH. Also opc=0, func=001000 -> JR with PCSrc=3.
- opc=111111: DECODE -> FETCH. No MemWrite or RegWrite is ever asserted.
- Assert rst during MEMWR: all enables drop to 0 in the same cycle. After release the FSM is in FETCH and MemRead=1 on the next cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Opcode/func constants, ALU codes, select codes and FSM states
//                shared by the multicycle control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

   // Opcodes (IR[31:26])
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_JAL   = 6'b000011;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_SLTI  = 6'b001010;

   // Function codes (IR[5:0])
   localparam logic [5:0] c_FN_JR    = 6'b001000;
   localparam logic [5:0] c_FN_ADD   = 6'b100000;
   localparam logic [5:0] c_FN_SUB   = 6'b100010;
   localparam logic [5:0] c_FN_AND   = 6'b100100;
   localparam logic [5:0] c_FN_OR    = 6'b100101;
   localparam logic [5:0] c_FN_SLT   = 6'b101010;

   // ALUOperation codes
   localparam logic [2:0] c_ALU_AND  = 3'b000;
   localparam logic [2:0] c_ALU_OR   = 3'b001;
   localparam logic [2:0] c_ALU_ADD  = 3'b010;
   localparam logic [2:0] c_ALU_SUB  = 3'b110;
   localparam logic [2:0] c_ALU_SLT  = 3'b111;

   // ALUSrcB selects
   localparam logic [1:0] c_SRCB_B     = 2'd0;
   localparam logic [1:0] c_SRCB_FOUR  = 2'd1;
   localparam logic [1:0] c_SRCB_IMM   = 2'd2;
   localparam logic [1:0] c_SRCB_IMMSH = 2'd3;

   // PCSrc selects
   localparam logic [1:0] c_PCSRC_ALU    = 2'd0;
   localparam logic [1:0] c_PCSRC_JUMP   = 2'd1;
   localparam logic [1:0] c_PCSRC_ALUOUT = 2'd2;
   localparam logic [1:0] c_PCSRC_REGA   = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RT_EX   = 4'd6,
      S_RT_WB   = 4'd7,
      S_ADDI_EX = 4'd8,
      S_SLTI_EX = 4'd9,
      S_IMM_WB  = 4'd10,
      S_BEQ     = 4'd11,
      S_BNE     = 4'd12,
      S_JUMP    = 4'd13,
      S_JAL     = 4'd14,
      S_JR      = 4'd15
   } state_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_control.sv
// ============================================================================
//  Module      : alu_control
//  Description : R-type func field to ALUOperation decoder (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
   import cpu_defs::*;
(
   input  logic [5:0] func,
   output logic [2:0] aluOperation
);

   always_comb begin
      aluOperation = c_ALU_ADD;
      case (func)
         c_FN_ADD: aluOperation = c_ALU_ADD;
         c_FN_SUB: aluOperation = c_ALU_SUB;
         c_FN_AND: aluOperation = c_ALU_AND;
         c_FN_OR:  aluOperation = c_ALU_OR;
         c_FN_SLT: aluOperation = c_ALU_SLT;
         default:  aluOperation = c_ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM for the multicycle MIPS-subset datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
   import cpu_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opc,
   input  logic [5:0] func,
   input  logic       zero,
   output logic       PCLoad,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       JalSig1,
   output logic       MemToReg,
   output logic       JalSig2,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOperation,
   output logic [1:0] PCSrc
);

   state_t     r_state;
   state_t     w_nextState;
   logic [2:0] w_rtAluOp;

   alu_control u_aluControl (
      .func         (func),
      .aluOperation (w_rtAluOp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState  = S_FETCH;
      PCLoad       = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      JalSig1      = 1'b0;
      MemToReg     = 1'b0;
      JalSig2      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = c_SRCB_B;
      ALUOperation = c_ALU_AND;
      PCSrc        = c_PCSRC_ALU;

      case (r_state)
         S_FETCH: begin
            MemRead      = 1'b1;
            IRWrite      = 1'b1;
            ALUSrcB      = c_SRCB_FOUR;
            ALUOperation = c_ALU_ADD;
            PCSrc        = c_PCSRC_ALU;
            PCLoad       = 1'b1;
            w_nextState  = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut here
            ALUSrcB      = c_SRCB_IMMSH;
            ALUOperation = c_ALU_ADD;
            case (opc)
               c_OP_RTYPE:       w_nextState = (func == c_FN_JR) ? S_JR : S_RT_EX;
               c_OP_LW, c_OP_SW: w_nextState = S_MEMADR;
               c_OP_BEQ:         w_nextState = S_BEQ;
               c_OP_BNE:         w_nextState = S_BNE;
               c_OP_J:           w_nextState = S_JUMP;
               c_OP_JAL:         w_nextState = S_JAL;
               c_OP_ADDI:        w_nextState = S_ADDI_EX;
               c_OP_SLTI:        w_nextState = S_SLTI_EX;
               default:          w_nextState = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = c_SRCB_IMM;
            ALUOperation = c_ALU_ADD;
            w_nextState  = (opc == c_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD        = 1'b1;
            MemRead     = 1'b1;
            w_nextState = S_MEMWB;
         end
         S_MEMWB: begin
            MemToReg    = 1'b1;
            RegWrite    = 1'b1;
            w_nextState = S_FETCH;
         end
         S_MEMWR: begin
            IorD        = 1'b1;
            MemWrite    = 1'b1;
            w_nextState = S_FETCH;
         end
         S_RT_EX: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = c_SRCB_B;
            ALUOperation = w_rtAluOp;
            w_nextState  = S_RT_WB;
         end
         S_RT_WB: begin
            RegDst      = 1'b1;
            RegWrite    = 1'b1;
            w_nextState = S_FETCH;
         end
         S_ADDI_EX, S_SLTI_EX: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = c_SRCB_IMM;
            ALUOperation = (r_state == S_SLTI_EX) ? c_ALU_SLT : c_ALU_ADD;
            w_nextState  = S_IMM_WB;
         end
         S_IMM_WB: begin
            RegWrite    = 1'b1;
            w_nextState = S_FETCH;
         end
         S_BEQ, S_BNE: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = c_SRCB_B;
            ALUOperation = c_ALU_SUB;
            PCSrc        = c_PCSRC_ALUOUT;
            PCLoad       = (r_state == S_BEQ) ? zero : ~zero;
            w_nextState  = S_FETCH;
         end
         S_JUMP: begin
            PCSrc       = c_PCSRC_JUMP;
            PCLoad      = 1'b1;
            w_nextState = S_FETCH;
         end
         S_JAL: begin
            // PC already holds PC+4 from FETCH, so it is the link value
            JalSig1     = 1'b1;
            JalSig2     = 1'b1;
            RegWrite    = 1'b1;
            PCSrc       = c_PCSRC_JUMP;
            PCLoad      = 1'b1;
            w_nextState = S_FETCH;
         end
         S_JR: begin
            PCSrc       = c_PCSRC_REGA;
            PCLoad      = 1'b1;
            w_nextState = S_FETCH;
         end
         default: begin
            w_nextState = S_FETCH;
         end
      endcase

      // Enables are cut combinationally so an aborted instruction writes nothing
      if (rst) begin
         PCLoad   = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

`default_nettype wire
